// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised FIFO: state codes and width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    // Last-operation state codes reported on the state output
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_WR_RD  = 3'd3,
        ST_WR_ERR = 3'd4,
        ST_RD_ERR = 3'd5
    } state_e;

    // Ceiling log2 used for pointer and counter widths (elaboration-time only)
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_param_regfile.sv
// DEPTH x DATA_W storage array with one write port and one asynchronous read port.
// Latency: write lands at the clock edge; read data is combinational from raddr_i.
// Backpressure: none; the caller only raises we_i for accepted writes.
module fifo_param_regfile
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  wsel;

    // One-hot decode of the write address, gated by the write enable
    always_comb begin
        wsel = '0;
        if (we_i) begin
            wsel[waddr_i] = 1'b1;
        end
    end

    // Storage is deliberately not reset; only the selected entry is updated
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wsel[i]) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with ack/err pulses, occupancy flags and last-operation state.
// Latency: rd_data/acks/errs one cycle after the accepting edge; flags track post-edge count.
// Backpressure: writes at full are rejected (wr_err) unless a read is accepted the same edge.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      wr_ack,
    output logic                      wr_err,
    output logic                      rd_ack,
    output logic                      rd_err,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [clog2(DEPTH):0]     data_count,
    output logic [2:0]                state
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_word;
    logic              wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
    logic              rd_ok, wr_ok;
    state_e            state_q, state_d;

    // A read needs data present; a write needs room or a same-edge read freeing a slot
    assign rd_ok = rd_en && (count_q != '0);
    assign wr_ok = wr_en && ((count_q != CW'(DEPTH)) || rd_ok);

    fifo_param_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk_i   (clk),
        .we_i    (wr_ok && reset_n),
        .waddr_i (head_q),
        .wdata_i (wr_data),
        .raddr_i (tail_q),
        .rdata_o (rd_word)
    );

    // Pointer and occupancy next-state; pointers wrap naturally at power-of-two depth
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (wr_ok) begin
            head_d = head_q + AW'(1);
        end
        if (rd_ok) begin
            tail_d = tail_q + AW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Datapath registers: pointers, count, read word and single-cycle pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wr_ack_q <= wr_ok;
            wr_err_q <= wr_en && !wr_ok;
            rd_ack_q <= rd_ok;
            rd_err_q <= rd_en && !rd_ok;
            if (rd_ok) begin
                rd_data_q <= rd_word;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state from this edge's outcome; a rejected write with an accepted read is READ
    always_comb begin
        state_d = ST_IDLE;
        if (wr_ok && rd_ok) begin
            state_d = ST_WR_RD;
        end else if (wr_ok) begin
            state_d = ST_WRITE;
        end else if (rd_ok) begin
            state_d = ST_READ;
        end else if (wr_en) begin
            state_d = ST_WR_ERR;
        end else if (rd_en) begin
            state_d = ST_RD_ERR;
        end
    end

    // FSM and status outputs
    always_comb begin
        state       = state_q;
        rd_data     = rd_data_q;
        wr_ack      = wr_ack_q;
        wr_err      = wr_err_q;
        rd_ack      = rd_ack_q;
        rd_err      = rd_err_q;
        data_count  = count_q;
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        almost_full = (count_q >= CW'(AFULL_TH));
    end

endmodule

// File: tb/tb_fifo_param.sv
// Directed scoreboard bench for fifo_param at DATA_W=32, DEPTH=8, AFULL_TH=6.
// Latency: status checked one cycle after each driven edge; read data checked on rd_ack.
// Backpressure: n/a (bench).
module tb_fifo_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        wr_ack, wr_err, rd_ack, rd_err;
    logic        full, empty, almost_full;
    logic [3:0]  data_count;
    logic [2:0]  state;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        bit         rst_chk;
        logic [2:0] st;
        int         cnt;
        bit         wa, we, ra, re;
    } exp_t;

    exp_t        sq[$];
    logic [31:0] dq[$];

    fifo_param #(
        .DATA_W   (32),
        .DEPTH    (8),
        .AFULL_TH (6)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .data_count  (data_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: read data on rd_ack against the data queue, status against the status queue
    initial begin
        exp_t e;
        logic [31:0] d;
        forever begin
            @(posedge clk);
            #1;
            if (rd_ack === 1'b1) begin
                if (dq.size() == 0) begin
                    cmp("unexpected_rd_ack", 64'd1, 64'd0);
                end else begin
                    d = dq.pop_front();
                    cmp("rd_data", 64'(rd_data), 64'(d));
                end
            end
            if (sq.size() > 0) begin
                e = sq.pop_front();
                cmp("state",       64'(state),       64'(e.st));
                cmp("data_count",  64'(data_count),  64'(e.cnt));
                cmp("full",        64'(full),        64'(e.cnt == 8));
                cmp("empty",       64'(empty),       64'(e.cnt == 0));
                cmp("almost_full", 64'(almost_full), 64'(e.cnt >= 6));
                cmp("wr_ack",      64'(wr_ack),      64'(e.wa));
                cmp("wr_err",      64'(wr_err),      64'(e.we));
                cmp("rd_ack",      64'(rd_ack),      64'(e.ra));
                cmp("rd_err",      64'(rd_err),      64'(e.re));
                if (e.rst_chk) begin
                    cmp("rd_data_after_reset", 64'(rd_data), 64'd0);
                end
            end
        end
    end

    // Drive one edge worth of requests and queue the hand-computed expectation
    task automatic op(input bit rst, input bit w, input logic [31:0] wd, input bit r,
                      input logic [2:0] st, input int cnt,
                      input bit wa, input bit we, input bit ra, input bit re,
                      input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        reset_n = !rst;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        e.rst_chk = rst;
        e.st  = st;
        e.cnt = cnt;
        e.wa  = wa;
        e.we  = we;
        e.ra  = ra;
        e.re  = re;
        sq.push_back(e);
        if (ra) dq.push_back(exp_rd);
    endtask

    task automatic wr_ok(input logic [31:0] d, input int cnt);
        op(0, 1, d, 0, 3'd1, cnt, 1, 0, 0, 0, '0);
    endtask

    task automatic rd_ok(input logic [31:0] d, input int cnt);
        op(0, 0, '0, 1, 3'd2, cnt, 0, 0, 1, 0, d);
    endtask

    task automatic idle(input int cnt);
        op(0, 0, '0, 0, 3'd0, cnt, 0, 0, 0, 0, '0);
    endtask

    initial begin
        // Reset, with requests asserted to show they are ignored
        op(1, 1, 32'hDEAD, 1, 3'd0, 0, 0, 0, 0, 0, '0);
        idle(0);

        // Fill with 0x11..0x88; almost_full from 6th, full at 8th
        for (int i = 1; i <= 8; i++) wr_ok(32'h11 * i, i);

        // Write at full is rejected
        op(0, 1, 32'h99, 0, 3'd4, 8, 0, 1, 0, 0, '0);

        // Drain in order, then an extra read is rejected
        for (int i = 1; i <= 8; i++) rd_ok(32'h11 * i, 8 - i);
        op(0, 0, '0, 1, 3'd5, 0, 0, 0, 0, 1, '0);

        // Wrap-around: write 5, read 5, write 6, read 6
        for (int i = 0; i < 5; i++) wr_ok(32'hA0 + i, i + 1);
        for (int i = 0; i < 5; i++) rd_ok(32'hA0 + i, 4 - i);
        for (int i = 0; i < 6; i++) wr_ok(32'hB0 + i, i + 1);
        for (int i = 0; i < 6; i++) rd_ok(32'hB0 + i, 5 - i);
        idle(0);

        // Simultaneous read+write at full: 0xAA comes out after the other 7
        for (int i = 0; i < 8; i++) wr_ok(32'hC0 + i, i + 1);
        op(0, 1, 32'hAA, 1, 3'd3, 8, 1, 0, 1, 0, 32'hC0);
        for (int i = 1; i < 8; i++) rd_ok(32'hC0 + i, 8 - i);
        rd_ok(32'hAA, 0);

        // Simultaneous read+write at empty: write accepted, read rejected
        op(0, 1, 32'hBB, 1, 3'd1, 1, 1, 0, 0, 1, '0);
        rd_ok(32'hBB, 0);

        // Mid-burst reset after 3 writes, then a read is rejected
        for (int i = 1; i <= 3; i++) wr_ok(32'h30 + i, i);
        op(1, 1, 32'h44, 1, 3'd0, 0, 0, 0, 0, 0, '0);
        op(0, 0, '0, 1, 3'd5, 0, 0, 0, 0, 1, '0);
        idle(0);

        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        cmp("status_queue_drained", 64'(sq.size()), 64'd0);
        cmp("data_queue_drained",   64'(dq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter DATA_W, 32, word width in bits (1..64).
REQ-002 Parameter DEPTH, 8, number of entries (power of two, 2..256).
REQ-003 Parameter AFULL_TH, DEPTH-2, data_count at or above which almost_full asserts (1..DEPTH).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 wr_en  input  1  write request.
REQ-007 wr_data  input  DATA_W  write word.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_data  output  DATA_W  registered read word.
REQ-010 wr_ack / wr_err  output  1 each  write accepted / rejected pulse.
REQ-011 rd_ack / rd_err  output  1 each  read accepted / rejected pulse.
REQ-012 full / empty / almost_full  output  1 each  occupancy flags.
REQ-013 data_count  output  clog2(DEPTH)+1  current occupancy.
REQ-014 state  output  3  last-operation state code.

Function
REQ-015 Storage: DEPTH x DATA_W register file; write pointer (head) and read pointer (tail) each clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-016 Write accepted at an edge when wr_en=1 and (full=0 or a read is accepted at the same edge); word stored at head, head+1.
REQ-017 Read accepted at an edge when rd_en=1 and empty=0; word at tail registered into rd_data, tail+1.
REQ-018 Simultaneous accepted read and write: data_count unchanged; at full, both accepted; at empty, write accepted, read rejected, data_count -> 1.
REQ-019 data_count: +1 on write only, -1 on read only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-020 full = (data_count==DEPTH), empty = (data_count==0), almost_full = (data_count>=AFULL_TH); all reflect post-edge occupancy with no extra latency.
REQ-021 Latency: rd_data and rd_ack valid in the cycle after the accepting edge; rd_data holds its value when no read is accepted.
REQ-022 wr_ack/wr_err/rd_ack/rd_err: single-cycle pulses in the cycle after the edge; wr_err = wr_en with write rejected; rd_err = rd_en with read rejected; ack and err of the same side are never both 1.
REQ-023 State machine, one transition per edge based on that edge's requests: IDLE(0) no request; WRITE(1) write only accepted; READ(2) read only accepted; WR_RD(3) both accepted; WR_ERR(4) write rejected, no read accepted; RD_ERR(5) read rejected, no write accepted; WR_RD takes priority when both are accepted; a rejected write with an accepted read gives READ plus wr_err.
REQ-024 Rejected operations do not alter storage, pointers or data_count.

Reset
REQ-025 When reset_n=0 at an edge: head=0, tail=0, data_count=0, state=IDLE, rd_data=0, all ack/err pulses 0; therefore empty=1, full=0, almost_full=0.
REQ-026 Reset overrides any concurrent wr_en/rd_en, including mid-burst; storage contents need not be cleared.

Structure
REQ-027 State codes and the clog2 helper are placed in shared package fifo_pkg.
REQ-028 Storage is a sub-module fifo_param_regfile (parameters DATA_W, DEPTH; write-address decode, write enable, combinational read mux); fifo_param holds pointers, counter, FSM and output registers.

Verification (DATA_W=32, DEPTH=8, AFULL_TH=6)
REQ-029 Reset, then write 0x11..0x88 on 8 consecutive cycles -> 8 wr_ack; almost_full rises after the 6th write, full after the 8th; data_count=8.
REQ-030 With FIFO full, a 9th write of 0x99 -> wr_err=1, state=WR_ERR, data_count stays 8, and the next read returns 0x11.
REQ-031 Drain 8 reads, then a 9th read -> data 0x11..0x88 in order one cycle after each read edge, then rd_err=1, state=RD_ERR, empty=1.
REQ-032 Wrap-around: write 5, read 5, write 6, read 6 -> output order preserved across pointer wrap, data_count returns to 0.
REQ-033 At full, simultaneous wr_en(0xAA) and rd_en -> state=WR_RD, data_count stays 8, 0xAA is read last after 7 further reads. At empty, simultaneous requests -> rd_err=1, data_count=1.
REQ-034 Assert reset_n=0 for one cycle after 3 writes -> data_count=0, empty=1, rd_data=0, state=IDLE; a following read gives rd_err=1.
